// File: rtl/hdlc_pkg.sv
// Shared constants and types for the HDLC receive deframer and its detector.
package hdlc_pkg;

    localparam int unsigned DET_W  = 10;
    localparam int unsigned S_RUN0 = 0;
    localparam int unsigned S_RUN1 = 1;
    localparam int unsigned S_RUN2 = 2;
    localparam int unsigned S_RUN3 = 3;
    localparam int unsigned S_RUN4 = 4;
    localparam int unsigned S_RUN5 = 5;
    localparam int unsigned S_RUN6 = 6;
    localparam int unsigned S_ERR  = 7;
    localparam int unsigned S_DISC = 8;
    localparam int unsigned S_FLAG = 9;

    localparam logic [DET_W-1:0] DET_RESET = 10'b00_0000_0001;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ABORT = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        FRAME
    } ctrl_state_t;

    typedef enum logic [2:0] {
        BC_DATA,
        BC_STUFF,
        BC_FLAG,
        BC_ABORT,
        BC_IGNORE
    } bit_class_t;

    // Abort is reported only on entry to the error state; further ones are ignored.
    function automatic bit_class_t classify(input logic flag_n, input logic err_n,
                                            input logic disc_n, input logic err_s);
        if (flag_n)
            return BC_FLAG;
        else if (err_n && !err_s)
            return BC_ABORT;
        else if (disc_n)
            return BC_STUFF;
        else if (err_n)
            return BC_IGNORE;
        else
            return BC_DATA;
    endfunction

endpackage

// File: rtl/hdlc_bit_detector.sv
// One-hot flag / stuffed-zero / abort detector, advanced once per accepted bit.
module hdlc_bit_detector
    import hdlc_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic [DET_W-1:0] state,
    output logic [DET_W-1:0] next_state
);

    always_comb begin
        next_state = '0;
        next_state[S_RUN0] = !in_bit & (state[S_RUN0] | state[S_RUN1] | state[S_RUN2] |
                                        state[S_RUN3] | state[S_RUN4] | state[S_ERR]  |
                                        state[S_DISC] | state[S_FLAG]);
        next_state[S_RUN1] = in_bit & (state[S_RUN0] | state[S_DISC] | state[S_FLAG]);
        for (int unsigned k = S_RUN2; k <= S_RUN6; k++)
            next_state[k] = in_bit & state[k-1];
        next_state[S_ERR]  = in_bit & (state[S_RUN6] | state[S_ERR]);
        next_state[S_DISC] = !in_bit & state[S_RUN5];
        next_state[S_FLAG] = !in_bit & state[S_RUN6];
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= DET_RESET;
        else if (in_valid)
            state <= next_state;
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: destuffs, strips flags and emits LSB-first bytes with
// SOP/EOP/abort markers. One byte is held back so EOP can ride on the last byte.
module hdlc_rx_deframer
    import hdlc_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 1024
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_abort,
    output logic [1:0] out_err,
    output logic       out_hunt
);

    localparam int unsigned          CNT_W   = $clog2(MAX_BYTES + 1);
    localparam logic [CNT_W-1:0]     MAX_CNT = CNT_W'(MAX_BYTES);

    logic [DET_W-1:0] det_state;
    logic [DET_W-1:0] det_next;
    logic             det_unused;
    bit_class_t       cls;

    ctrl_state_t      ctrl;
    logic [6:0]       dly;
    logic [2:0]       fill;
    logic             commit;
    logic             commit_bit;
    logic [7:0]       shreg;
    logic [7:0]       new_byte;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       hold;
    logic             hold_full;
    logic             first;

    hdlc_bit_detector u_det (
        .clk        (clk),
        .resetn     (resetn),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .state      (det_state),
        .next_state (det_next)
    );

    assign det_unused = ^{det_state, det_next};
    assign cls        = classify(det_next[S_FLAG], det_next[S_ERR], det_next[S_DISC],
                                 det_state[S_ERR]);
    assign commit     = in_valid && (cls == BC_DATA) && (fill == 3'd7);
    assign commit_bit = dly[6];
    assign new_byte   = {commit_bit, shreg[7:1]};

    // Seven-bit delay so the leading 0111111 of a flag never reaches the byte path.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dly  <= '0;
            fill <= '0;
        end else if (in_valid) begin
            case (cls)
                BC_DATA: begin
                    dly <= {dly[5:0], in_bit};
                    if (fill != 3'd7)
                        fill <= fill + 3'd1;
                end
                BC_FLAG, BC_ABORT: begin
                    dly  <= '0;
                    fill <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl      <= HUNT;
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            first     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_abort <= 1'b0;
            out_err   <= ERR_NONE;
            out_hunt  <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_abort <= 1'b0;
            out_err   <= ERR_NONE;
            if (in_valid) begin
                case (ctrl)
                    HUNT: begin
                        if (cls == BC_FLAG) begin
                            ctrl     <= SYNC;
                            out_hunt <= 1'b0;
                        end
                    end
                    SYNC: begin
                        if (cls == BC_ABORT) begin
                            ctrl     <= HUNT;
                            out_hunt <= 1'b1;
                        end else if (commit) begin
                            ctrl    <= FRAME;
                            shreg   <= new_byte;
                            bit_cnt <= 3'd1;
                            first   <= 1'b1;
                        end
                    end
                    FRAME: begin
                        if (cls == BC_FLAG || cls == BC_ABORT) begin
                            if (cls == BC_ABORT) begin
                                out_abort <= 1'b1;
                                out_err   <= ERR_ABORT;
                                ctrl      <= HUNT;
                                out_hunt  <= 1'b1;
                            end else begin
                                ctrl <= SYNC;
                                if (bit_cnt != 3'd0) begin
                                    out_abort <= 1'b1;
                                    out_err   <= ERR_ALIGN;
                                end else if (hold_full) begin
                                    out_data  <= hold;
                                    out_valid <= 1'b1;
                                    out_sop   <= first;
                                    out_eop   <= 1'b1;
                                end
                            end
                            bit_cnt   <= '0;
                            byte_cnt  <= '0;
                            hold      <= '0;
                            hold_full <= 1'b0;
                            first     <= 1'b0;
                        end else if (commit) begin
                            shreg   <= new_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_cnt >= MAX_CNT) begin
                                    out_abort <= 1'b1;
                                    out_err   <= ERR_SIZE;
                                    ctrl      <= HUNT;
                                    out_hunt  <= 1'b1;
                                    bit_cnt   <= '0;
                                    byte_cnt  <= '0;
                                    hold      <= '0;
                                    hold_full <= 1'b0;
                                    first     <= 1'b0;
                                end else begin
                                    byte_cnt  <= byte_cnt + 1'b1;
                                    hold      <= new_byte;
                                    hold_full <= 1'b1;
                                    if (hold_full) begin
                                        out_data  <= hold;
                                        out_valid <= 1'b1;
                                        out_sop   <= first;
                                        first     <= 1'b0;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        ctrl     <= HUNT;
                        out_hunt <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench: two deframers (default and MAX_BYTES=4) fed the same bit stream.
module tb_hdlc_rx_deframer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;

    logic [7:0] data_b, data_s;
    logic       valid_b, valid_s, sop_b, sop_s, eop_b, eop_s, abort_b, abort_s, hunt_b, hunt_s;
    logic [1:0] err_b, err_s;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          ones = 0;
    bit          gaps = 1'b0;

    logic [12:0] q_big[$];
    logic [12:0] q_small[$];
    logic [12:0] obs_b, obs_s;

    always #5 clk = ~clk;

    hdlc_rx_deframer dut_big (
        .clk(clk), .resetn(resetn), .in_bit(in_bit), .in_valid(in_valid),
        .out_data(data_b), .out_valid(valid_b), .out_sop(sop_b), .out_eop(eop_b),
        .out_abort(abort_b), .out_err(err_b), .out_hunt(hunt_b)
    );

    hdlc_rx_deframer #(.MAX_BYTES(4)) dut_small (
        .clk(clk), .resetn(resetn), .in_bit(in_bit), .in_valid(in_valid),
        .out_data(data_s), .out_valid(valid_s), .out_sop(sop_s), .out_eop(eop_s),
        .out_abort(abort_s), .out_err(err_s), .out_hunt(hunt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] ev_data(input logic [7:0] d, input logic sop, input logic eop);
        return {1'b0, 1'b1, 2'b00, sop, eop, d};
    endfunction

    function automatic logic [12:0] ev_abort(input logic [1:0] err);
        return {1'b1, 1'b0, err, 2'b00, 8'h00};
    endfunction

    always @(negedge clk) begin
        if (valid_b || abort_b || sop_b || eop_b || (err_b != 2'b00)) begin
            obs_b = {abort_b, valid_b, err_b, sop_b, eop_b, abort_b ? 8'h00 : data_b};
            if (q_big.size() == 0)
                check("big_unexpected", obs_b, 32'h0);
            else
                check("big_out", obs_b, q_big.pop_front());
        end
    end

    always @(negedge clk) begin
        if (valid_s || abort_s || sop_s || eop_s || (err_s != 2'b00)) begin
            obs_s = {abort_s, valid_s, err_s, sop_s, eop_s, abort_s ? 8'h00 : data_s};
            if (q_small.size() == 0)
                check("small_unexpected", obs_s, 32'h0);
            else
                check("small_out", obs_s, q_small.pop_front());
        end
    end

    task automatic send_bit(input logic b);
        if (gaps)
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++)
            send_bit(f[i]);
        ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (d[i]) begin
                ones++;
                if (ones == 5) begin
                    send_bit(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
    endtask

    task automatic push_both(input logic [12:0] ev);
        q_big.push_back(ev);
        q_small.push_back(ev);
    endtask

    task automatic drain(input string tag);
        idle(4);
        check({tag, "_big_pending"}, q_big.size(), 0);
        check({tag, "_small_pending"}, q_small.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_outs_big"}, {data_b, valid_b, sop_b, eop_b, abort_b, err_b}, 0);
        check({tag, "_hunt_big"}, hunt_b, 1);
        check({tag, "_outs_small"}, {data_s, valid_s, sop_s, eop_s, abort_s, err_s}, 0);
        check({tag, "_hunt_small"}, hunt_s, 1);
    endtask

    task automatic scenario_two();
        push_both(ev_data(8'hA5, 1'b1, 1'b0));
        push_both(ev_data(8'h3C, 1'b0, 1'b1));
        send_flag();
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_flag();
    endtask

    initial begin
        logic [7:0] fl;
        logic [7:0] big_frame [6];
        big_frame = '{8'h11, 8'h22, 8'h7E, 8'h44, 8'hF0, 8'h0F};

        resetn   = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        resetn = 1'b1;

        // Three flags; hunt must drop only after the first flag's closing zero.
        fl = 8'h7E;
        for (int i = 0; i < 7; i++)
            send_bit(fl[i]);
        idle(1);
        check("t1_hunt_pre", hunt_b, 1);
        send_bit(fl[7]);
        idle(1);
        check("t1_hunt_big", hunt_b, 0);
        check("t1_hunt_small", hunt_s, 0);
        ones = 0;
        send_flag();
        send_flag();
        drain("t1");

        scenario_two();
        drain("t2");

        push_both(ev_data(8'hFF, 1'b1, 1'b1));
        send_flag();
        send_byte(8'hFF);
        send_flag();
        drain("t3");

        push_both(ev_data(8'h12, 1'b1, 1'b0));
        push_both(ev_abort(2'b01));
        send_flag();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        repeat (7) send_bit(1'b1);
        idle(2);
        check("t4_hunt_big", hunt_b, 1);
        check("t4_hunt_small", hunt_s, 1);
        push_both(ev_data(8'h55, 1'b1, 1'b1));
        send_flag();
        send_byte(8'h55);
        send_flag();
        drain("t4");

        push_both(ev_abort(2'b10));
        send_flag();
        send_byte(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_flag();
        drain("t5a");

        for (int i = 0; i < 6; i++)
            q_big.push_back(ev_data(big_frame[i], i == 0, i == 5));
        for (int i = 0; i < 3; i++)
            q_small.push_back(ev_data(big_frame[i], i == 0, 1'b0));
        q_small.push_back(ev_abort(2'b11));
        send_flag();
        for (int i = 0; i < 6; i++)
            send_byte(big_frame[i]);
        idle(2);
        check("t5b_hunt_big", hunt_b, 0);
        check("t5b_hunt_small", hunt_s, 1);
        send_flag();
        drain("t5b");

        gaps = 1'b1;
        scenario_two();
        drain("t6_gaps");
        gaps = 1'b0;

        fl = 8'h3C;
        send_flag();
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++)
            send_bit(fl[i]);
        @(negedge clk);
        in_valid = 1'b0;
        resetn   = 1'b0;
        @(negedge clk);
        check_reset_state("t6_reset");
        resetn = 1'b1;
        push_both(ev_data(8'h5A, 1'b1, 1'b1));
        send_flag();
        send_byte(8'h5A);
        send_flag();
        drain("t6_recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
